// File: rtl/nibble_serial_cla_adder.sv
// Multi-cycle adder: one 4-bit lookahead nibble per clock, LSB nibble first, valid/ready on both sides.
// Optional signed-overflow output is enabled by defining CLA_SIGNED_OVF_EN.
module nibble_serial_cla_adder #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
`ifdef CLA_SIGNED_OVF_EN
   output logic             ovf,
`endif
   output logic             cout
);

   localparam int NIB = WIDTH / 4;
   localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_r;
   logic [IW-1:0]    idx_r;
   logic             carry_r;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;

   logic [3:0] nib_a;
   logic [3:0] nib_b;
   logic [3:0] nib_g;
   logic [3:0] nib_p;
   logic [4:1] nib_c;
   logic [3:0] nib_sum;

   // Carries c1..c4 of a 4-bit block, fully expanded lookahead form.
   function automatic logic [4:1] cla4_carries(input logic [3:0] g, input logic [3:0] p,
                                               input logic ci);
      logic [4:1] c;
      c[1] = g[0] | (p[0] & ci);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & ci);
      return c;
   endfunction

   // Lookahead datapath for the nibble selected by the current index.
   always_comb begin
      nib_a   = a_r[{idx_r, 2'b00} +: 4];
      nib_b   = b_r[{idx_r, 2'b00} +: 4];
      nib_g   = nib_a & nib_b;
      nib_p   = nib_a ^ nib_b;
      nib_c   = cla4_carries(nib_g, nib_p, carry_r);
      nib_sum = nib_p ^ {nib_c[3], nib_c[2], nib_c[1], carry_r};
   end

   // Control FSM with registered handshake and result outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= IDLE;
         idx_r     <= {IW{1'b0}};
         carry_r   <= 1'b0;
         a_r       <= {WIDTH{1'b0}};
         b_r       <= {WIDTH{1'b0}};
         sum       <= {WIDTH{1'b0}};
         cout      <= 1'b0;
`ifdef CLA_SIGNED_OVF_EN
         ovf       <= 1'b0;
`endif
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
      end else begin
         case (state_r)
            IDLE: begin
               if (in_valid) begin
                  a_r      <= a;
                  b_r      <= b;
                  carry_r  <= cin;
                  idx_r    <= {IW{1'b0}};
                  in_ready <= 1'b0;
                  state_r  <= RUN;
               end else begin
                  in_ready <= 1'b1;
               end
            end
            RUN: begin
               sum[{idx_r, 2'b00} +: 4] <= nib_sum;
               carry_r                  <= nib_c[4];
               if (idx_r == IW'(NIB - 1)) begin
                  cout      <= nib_c[4];
`ifdef CLA_SIGNED_OVF_EN
                  ovf       <= nib_c[4] ^ nib_c[3];
`endif
                  out_valid <= 1'b1;
                  idx_r     <= {IW{1'b0}};
                  state_r   <= DONE;
               end else begin
                  idx_r <= idx_r + IW'(1);
               end
            end
            DONE: begin
               // Result held stable until the consumer takes it; no same-cycle re-accept.
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state_r   <= IDLE;
               end else begin
                  out_valid <= 1'b1;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state_r   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_nibble_serial_cla_adder.sv
// Self-checking bench: directed cases plus random vectors on WIDTH=16 and WIDTH=4 instances,
// checked against plain a+b+cin arithmetic.
module tb_nibble_serial_cla_adder;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, out_valid, out_ready, cin, cout;
   logic [15:0] a, b, sum;
`ifdef CLA_SIGNED_OVF_EN
   logic        ovf;
`endif

   logic       in_valid4, in_ready4, out_valid4, out_ready4, cin4, cout4;
   logic [3:0] a4, b4, sum4;
`ifdef CLA_SIGNED_OVF_EN
   logic       ovf4;
`endif

   int n_compared   = 0;
   int n_mismatched = 0;

   always #5 clk = ~clk;

   nibble_serial_cla_adder #(.WIDTH(16)) u_dut (
`ifdef CLA_SIGNED_OVF_EN
      .ovf(ovf),
`endif
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
      .cin(cin), .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout)
   );

   nibble_serial_cla_adder #(.WIDTH(4)) u_dut4 (
`ifdef CLA_SIGNED_OVF_EN
      .ovf(ovf4),
`endif
      .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .a(a4), .b(b4),
      .cin(cin4), .out_valid(out_valid4), .out_ready(out_ready4), .sum(sum4), .cout(cout4)
   );

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_compared++;
      if (obs !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full transaction on the 16-bit instance, checked against integer arithmetic.
   task automatic do_add(input logic [15:0] aa, input logic [15:0] bb, input logic cc,
                         input int hold, input bit inject);
      logic [16:0] ref_full;
      int          waited;
      int          lat;
      ref_full = {1'b0, aa} + {1'b0, bb} + {16'd0, cc};
      waited = 0;
      while (!in_ready && waited < 12) begin
         tick();
         waited++;
      end
      check_eq("in_ready_before_accept", {63'd0, in_ready}, 64'd1);
      a = aa; b = bb; cin = cc; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      lat = 0;
      check_eq("in_ready_in_run", {63'd0, in_ready}, 64'd0);
      if (inject) begin
         a = 16'(~aa); b = 16'($urandom); cin = ~cc; in_valid = 1'b1;
         tick();
         in_valid = 1'b0;
         lat = 1;
      end
      while (!out_valid && lat < 20) begin
         tick();
         lat++;
      end
      check_eq("latency", 64'(lat), 64'd4);
      check_eq("sum", {48'd0, sum}, {48'd0, ref_full[15:0]});
      check_eq("cout", {63'd0, cout}, {63'd0, ref_full[16]});
`ifdef CLA_SIGNED_OVF_EN
      check_eq("ovf", {63'd0, ovf},
               {63'd0, (aa[15] == bb[15]) && (ref_full[15] != aa[15])});
`endif
      check_eq("in_ready_in_done", {63'd0, in_ready}, 64'd0);
      for (int h = 0; h < hold; h++) begin
         tick();
         check_eq("hold_valid", {63'd0, out_valid}, 64'd1);
         check_eq("hold_sum", {47'd0, cout, sum}, {47'd0, ref_full});
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check_eq("valid_after_accept", {63'd0, out_valid}, 64'd0);
      check_eq("ready_after_accept", {63'd0, in_ready}, 64'd1);
   endtask

   initial begin
      logic [4:0] ref4;
      int         quiet;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = 16'd0; b = 16'd0; cin = 1'b0;
      in_valid4 = 1'b0; out_ready4 = 1'b0; a4 = 4'd0; b4 = 4'd0; cin4 = 1'b0;
      #2;
      check_eq("rst_sum", {48'd0, sum}, 64'd0);
      check_eq("rst_cout", {63'd0, cout}, 64'd0);
      check_eq("rst_valid", {63'd0, out_valid}, 64'd0);
      check_eq("rst_ready", {63'd0, in_ready}, 64'd1);
      #10 rst = 1'b0;
      tick();

      do_add(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0);
      do_add(16'h1234, 16'h4321, 1'b1, 0, 1'b0);
      do_add(16'h1234, 16'h4321, 1'b1, 5, 1'b0);
      do_add(16'h1234, 16'h4321, 1'b1, 0, 1'b1);
      do_add(16'h7FFF, 16'h0001, 1'b0, 0, 1'b0);
      do_add(16'h8000, 16'h8000, 1'b1, 1, 1'b0);

      // Abort during the second RUN cycle.
      a = 16'hAAAA; b = 16'h5555; cin = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      rst = 1'b1;
      #1;
      check_eq("abort_sum", {48'd0, sum}, 64'd0);
      check_eq("abort_cout", {63'd0, cout}, 64'd0);
      check_eq("abort_valid", {63'd0, out_valid}, 64'd0);
      check_eq("abort_ready", {63'd0, in_ready}, 64'd1);
      tick();
      rst = 1'b0;
      quiet = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (out_valid) quiet++;
      end
      check_eq("abort_no_valid", 64'(quiet), 64'd0);
      do_add(16'h0F0F, 16'h00F1, 1'b0, 0, 1'b0);

      for (int i = 0; i < 300; i++)
         do_add(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1'b0);

      for (int i = 0; i < 300; i++) begin
         a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
         ref4 = {1'b0, a4} + {1'b0, b4} + {4'd0, cin4};
         check_eq("w4_ready", {63'd0, in_ready4}, 64'd1);
         in_valid4 = 1'b1;
         tick();
         in_valid4 = 1'b0;
         check_eq("w4_not_yet", {63'd0, out_valid4}, 64'd0);
         tick();
         check_eq("w4_valid", {63'd0, out_valid4}, 64'd1);
         check_eq("w4_result", {59'd0, cout4, sum4}, {59'd0, ref4});
`ifdef CLA_SIGNED_OVF_EN
         check_eq("w4_ovf", {63'd0, ovf4}, {63'd0, (a4[3] == b4[3]) && (ref4[3] != a4[3])});
`endif
         out_ready4 = 1'b1;
         tick();
         out_ready4 = 1'b0;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
